gopf_mul_arb: RTL

GOPF_MUL_ARB -- requirements
Module: gopf_mul_arb

---
 rtl/gopf_pkg.sv | 8 +
 rtl/gopf_mul_arb_rr_pick.sv | 21 ++
 rtl/gopf_mul_arb.sv | 118 +++++++++++
 3 files changed

// File: rtl/gopf_pkg.sv
// gopf_pkg: shared sizes and FSM state encoding for the modular-multiplier arbiter.
package gopf_pkg;
    localparam int P_M       = 144;
    localparam int P_N_REQ   = 3;
    localparam int P_TIMEOUT = 1023;
    localparam int CNT_W     = 10;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;
endpackage

// File: rtl/gopf_mul_arb_rr_pick.sv
// rr_pick: round-robin picker; the requester just after ptr has the highest priority.
module rr_pick #(
    parameter int N = 3
) (
    input  logic [N-1:0] req,
    input  logic [1:0]   ptr,
    output logic [N-1:0] gnt,
    output logic [1:0]   idx
);
    always_comb begin
        gnt = '0;
        idx = '0;
        // Walk from farthest to nearest so the nearest pending request wins.
        for (int k = N; k >= 1; k--) begin
            if (req[(int'(ptr) + k) % N]) begin
                idx = 2'((int'(ptr) + k) % N);
                gnt = N'(1) << ((int'(ptr) + k) % N);
            end
        end
    end
endmodule

// File: rtl/gopf_mul_arb.sv
// gopf_mul_arb: arbitrates several requesters onto one shared modular multiplier
// with a timeout on the multiplier's completion pulse.
module gopf_mul_arb
    import gopf_pkg::*;
#(
    parameter int M       = P_M,
    parameter int N_REQ   = P_N_REQ,
    parameter int TIMEOUT = P_TIMEOUT
) (
    input  logic               clk,
    input  logic               rst_b,
    input  logic [N_REQ-1:0]   req_vld,
    input  logic [N_REQ*M-1:0] req_a,
    input  logic [N_REQ*M-1:0] req_b,
    input  logic [N_REQ*M-1:0] req_mod,
    output logic [N_REQ-1:0]   rsp_ack,
    output logic [M-1:0]       rsp_dat,
    output logic               rsp_err,
    output logic               busy,
    output logic [1:0]         grant_id,
    output logic               mul_start,
    output logic [M-1:0]       mul_multiplicand,
    output logic [M-1:0]       mul_multiplier,
    output logic [M-1:0]       mul_mod,
    input  logic [M-1:0]       mul_out,
    input  logic               mul_done
);
    state_e             state_q, state_d;
    logic [1:0]         ptr_q, ptr_d, gid_q, gid_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [M-1:0]       opa_q, opa_d, opb_q, opb_d, opm_q, opm_d, dat_q, dat_d;
    logic               err_q, err_d;
    logic [N_REQ-1:0]   pick_gnt;
    logic [1:0]         pick_idx;

    rr_pick #(.N(N_REQ)) u_pick (
        .req (req_vld),
        .ptr (ptr_q),
        .gnt (pick_gnt),
        .idx (pick_idx)
    );

    always_ff @(posedge clk) begin
        if (rst_b) begin
            state_q <= IDLE;
            ptr_q   <= 2'(N_REQ - 1);
            gid_q   <= '0;
            cnt_q   <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            opm_q   <= '0;
            dat_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gid_q   <= gid_d;
            cnt_q   <= cnt_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            opm_q   <= opm_d;
            dat_q   <= dat_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gid_d   = gid_q;
        cnt_d   = cnt_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        opm_d   = opm_q;
        dat_d   = dat_q;
        err_d   = err_q;
        case (state_q)
            IDLE: if (|pick_gnt) begin
                state_d = ISSUE;
                ptr_d   = pick_idx;
                gid_d   = pick_idx;
                opa_d   = req_a[int'(pick_idx)*M +: M];
                opb_d   = req_b[int'(pick_idx)*M +: M];
                opm_d   = req_mod[int'(pick_idx)*M +: M];
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            // A completion in the last allowed cycle still beats the timeout.
            WAIT: if (mul_done) begin
                dat_d   = mul_out;
                err_d   = 1'b0;
                state_d = RESP;
            end else if (cnt_q == CNT_W'(TIMEOUT)) begin
                dat_d   = '0;
                err_d   = 1'b1;
                state_d = RESP;
            end else begin
                cnt_d   = cnt_q + 1'b1;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rsp_ack          = (state_q == RESP) ? N_REQ'(1) << gid_q : '0;
        rsp_dat          = (state_q == RESP) ? dat_q : '0;
        rsp_err          = (state_q == RESP) & err_q;
        busy             = state_q != IDLE;
        mul_start        = state_q == ISSUE;
        grant_id         = gid_q;
        mul_multiplicand = opa_q;
        mul_multiplier   = opb_q;
        mul_mod          = opm_q;
    end
endmodule
